// File: rtl/sync_fifo_prog_if.sv
// Handshake/data bundle between a same-clock producer/consumer and sync_fifo_prog.
interface sync_fifo_prog_if #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH = 8
);
  logic                       sclr;
  logic                       wrreq;
  logic [FIFO_DATA_WIDTH-1:0] data;
  logic                       rdreq;
  logic                       err_clr;
  logic [FIFO_DATA_WIDTH-1:0] q;
  logic [FIFO_ADDR_WIDTH:0]   usedw;
  logic                       full;
  logic                       empty;
  logic                       prog_full;
  logic                       prog_empty;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output sclr, wrreq, data, rdreq, err_clr,
    input  q, usedw, full, empty, prog_full, prog_empty, overflow, underflow
  );

  modport slave (
    input  sclr, wrreq, data, rdreq, err_clr,
    output q, usedw, full, empty, prog_full, prog_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable show-ahead/normal read, full-range usedw,
// programmable full/empty levels, synchronous clear and sticky error flags.
module sync_fifo_prog #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int SHOW_AHEAD      = 1,
  parameter int PROG_FULL_THR   = 248,
  parameter int PROG_EMPTY_THR  = 8
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_prog_if.slave fifo
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_W = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0] ONE_W   = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_WIDTH:0] PF_LVL  = (FIFO_ADDR_WIDTH+1)'(PROG_FULL_THR);
  localparam logic [FIFO_ADDR_WIDTH:0] PE_LVL  = (FIFO_ADDR_WIDTH+1)'(PROG_EMPTY_THR);

  if (PROG_EMPTY_THR < 0 || PROG_EMPTY_THR >= PROG_FULL_THR || PROG_FULL_THR > DEPTH) begin : g_bad_thr
    $error("sync_fifo_prog: need 0 <= PROG_EMPTY_THR < PROG_FULL_THR <= DEPTH");
  end

  logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [FIFO_ADDR_WIDTH:0]   usedw_r, usedw_nxt;
  logic                       empty_r, full_r, pf_r, pe_r, ovf_r, udf_r;
  logic [FIFO_DATA_WIDTH-1:0] q_r;
  logic                       wr_acc, rd_acc, clr, head_last;

  // Accept decisions and next occupancy, all from the registered flags
  always_comb begin
    clr        = reset | fifo.sclr;
    wr_acc     = fifo.wrreq & ~full_r;
    rd_acc     = fifo.rdreq & ~empty_r;
    rd_ptr_inc = rd_ptr + 1'b1;
    head_last  = (usedw_r == ONE_W);
    usedw_nxt  = usedw_r;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw_r + 1'b1;
      2'b01:   usedw_nxt = usedw_r - 1'b1;
      default: usedw_nxt = usedw_r;
    endcase
  end

  // Storage write port; a clear cycle never stores a word
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr] <= fifo.data;
    end
  end

  // Pointers, occupancy, level flags and sticky error flags
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      pf_r    <= 1'b0;
      pe_r    <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr_inc;
      usedw_r <= usedw_nxt;
      empty_r <= (usedw_nxt == '0);
      full_r  <= (usedw_nxt == DEPTH_W);
      pf_r    <= (usedw_nxt >= PF_LVL);
      pe_r    <= (usedw_nxt <= PE_LVL);
      ovf_r   <= (fifo.wrreq & full_r)  | (ovf_r & ~fifo.err_clr);
      udf_r   <= (fifo.rdreq & empty_r) | (udf_r & ~fifo.err_clr);
    end
  end

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    // Registered head word: loaded straight from the write bus when the new word
    // becomes the head (write into empty, or write+pop with one word stored),
    // otherwise prefetched from RAM at rd_ptr+1 on a pop that leaves words behind.
    always_ff @(posedge clk) begin
      if (clr) begin
        q_r <= '0;
      end else if (wr_acc && (empty_r || (rd_acc && head_last))) begin
        q_r <= fifo.data;
      end else if (rd_acc && !head_last) begin
        q_r <= mem[rd_ptr_inc];
      end
    end
  end else begin : g_normal
    // Registered read: head word appears on q one edge after the accepted read
    always_ff @(posedge clk) begin
      if (clr) begin
        q_r <= '0;
      end else if (rd_acc) begin
        q_r <= mem[rd_ptr];
      end
    end
  end

  assign fifo.q          = q_r;
  assign fifo.usedw      = usedw_r;
  assign fifo.full       = full_r;
  assign fifo.empty      = empty_r;
  assign fifo.prog_full  = pf_r;
  assign fifo.prog_empty = pe_r;
  assign fifo.overflow   = ovf_r;
  assign fifo.underflow  = udf_r;

endmodule
